// File: rtl/mem_responder.sv
// mem_responder: IMEM/DMEM request responder backed by one shared 32-bit word array.
// Latency: resp pulses for one cycle IMEM_LATENCY / DMEM_LATENCY cycles after acceptance (1..15).
// Backpressure: none; each port accepts only from IDLE, so one access per LATENCY+1 cycles per port.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h1eceb000,
   parameter int unsigned IMEM_LATENCY = 1,
   parameter int unsigned DMEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic        oob_err
);
   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Counter preload; zero means the access goes straight to RESP.
   localparam logic [3:0] I_LOAD = 4'(IMEM_LATENCY - 1);
   localparam logic [3:0] D_LOAD = 4'(DMEM_LATENCY - 1);

   // Array size in bytes, one bit wider so huge depths cannot overflow the compare.
   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

   logic [31:0] r_mem [DEPTH_WORDS];

   logic [1:0]  r_i_state;
   logic [3:0]  r_i_cnt;
   logic [31:0] r_i_addr;

   logic [1:0]  r_d_state;
   logic [3:0]  r_d_cnt;
   logic [31:0] r_d_addr;
   logic [3:0]  r_d_wmask;
   logic [31:0] r_d_wdata;
   logic        r_oob;

   // Decode of the captured addresses; subtraction wraps below BASE_ADDR into out-of-range.
   logic [31:0]   w_i_off;
   logic [31:0]   w_d_off;
   logic          w_i_inrng;
   logic          w_d_inrng;
   logic [AW-1:0] w_i_idx;
   logic [AW-1:0] w_d_idx;
   logic          w_d_req;

   assign w_i_off   = r_i_addr - BASE_ADDR;
   assign w_d_off   = r_d_addr - BASE_ADDR;
   assign w_i_inrng = ({1'b0, w_i_off} < SPAN_BYTES);
   assign w_d_inrng = ({1'b0, w_d_off} < SPAN_BYTES);
   assign w_i_idx   = w_i_off[AW+1:2];
   assign w_d_idx   = w_d_off[AW+1:2];
   assign w_d_req   = (dmem_rmask != 4'b0) || (dmem_wmask != 4'b0);

   // Reads are combinational in RESP, so a same-cycle store (committed at the closing edge) is not seen.
   assign imem_resp  = (r_i_state == S_RESP);
   assign dmem_resp  = (r_d_state == S_RESP);
   assign imem_rdata = (imem_resp && w_i_inrng) ? r_mem[w_i_idx] : 32'h0;
   assign dmem_rdata = (dmem_resp && w_d_inrng) ? r_mem[w_d_idx] : 32'h0;
   assign oob_err    = r_oob;

   // IMEM FSM: capture on acceptance, count down, leave RESP after one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i_state <= S_IDLE;
         r_i_cnt   <= 4'd0;
         r_i_addr  <= 32'h0;
      end else begin
         case (r_i_state)
            S_IDLE: begin
               if (imem_rmask != 4'b0) begin
                  r_i_addr  <= imem_addr;
                  r_i_cnt   <= I_LOAD;
                  r_i_state <= (I_LOAD == 4'd0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               // RESP is entered on the edge where the counter reaches zero.
               r_i_cnt <= r_i_cnt - 4'd1;
               if (r_i_cnt <= 4'd1) r_i_state <= S_RESP;
            end
            default: r_i_state <= S_IDLE;
         endcase
      end
   end

   // DMEM FSM: same sequencing, additionally captures store enables and data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d_state <= S_IDLE;
         r_d_cnt   <= 4'd0;
         r_d_addr  <= 32'h0;
         r_d_wmask <= 4'b0;
         r_d_wdata <= 32'h0;
      end else begin
         case (r_d_state)
            S_IDLE: begin
               if (w_d_req) begin
                  r_d_addr  <= dmem_addr;
                  r_d_wmask <= dmem_wmask;
                  r_d_wdata <= dmem_wdata;
                  r_d_cnt   <= D_LOAD;
                  r_d_state <= (D_LOAD == 4'd0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               r_d_cnt <= r_d_cnt - 4'd1;
               if (r_d_cnt <= 4'd1) r_d_state <= S_RESP;
            end
            default: r_d_state <= S_IDLE;
         endcase
      end
   end

   // Store commit on the edge closing the DMEM RESP cycle; reset forces IDLE so aborted stores never land.
   always_ff @(posedge clk) begin
      if (dmem_resp && w_d_inrng) begin
         for (int b = 0; b < 4; b++) begin
            if (r_d_wmask[b]) r_mem[w_d_idx][8*b +: 8] <= r_d_wdata[8*b +: 8];
         end
      end
   end

   // Sticky out-of-range flag, raised when an out-of-range access completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_oob <= 1'b0;
      end else if ((imem_resp && !w_i_inrng) || (dmem_resp && !w_d_inrng)) begin
         r_oob <= 1'b1;
      end
   end

endmodule
